instr_fetch: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/instr_fetch.sv | 158 +++++++++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS front-end definitions.
//   - primary opcode constants decoded by control_unit
//   - canonical nop encoding
//   - instruction fetch FSM state encoding
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE  = 2'd0;
  localparam fetch_state_t REQ   = 2'd1;
  localparam fetch_state_t SKID  = 2'd2;
  localparam fetch_state_t DRAIN = 2'd3;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a fetched instruction and its PC+4.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture in_instr/in_pc_plus4
//   unload            entry moved downstream; clear it
//   flush             discard the entry (wins over load)
//   in_instr/in_pc_plus4    data to capture
//   out_instr/out_pc_plus4  held entry (zero when empty)
// Occupancy is tracked by the fetch FSM (SKID state), so no full flag lives here.
module fetch_skid_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc_plus4,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc_plus4
);

  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_plus4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end else if (flush) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end else if (load) begin
      instr_q    <= in_instr;
      pc_plus4_q <= in_pc_plus4;
    end else if (unload) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end
  end

  assign out_instr    = instr_q;
  assign out_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding control_unit.
// Owns the PC, runs a single-outstanding-request imem handshake and holds the IF/ID register.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   redirect_en, redirect_pc  branch/jump redirect pulse and target (bits [1:0] ignored)
//   stall                     decode cannot consume if_instr this cycle
//   imem_req, imem_addr       fetch request/address (held until imem_ack)
//   imem_ack, imem_rdata      memory response
//   if_instr, if_pc_plus4     IF/ID register contents
//   if_valid                  IF/ID register holds a live instruction
//   opcode, funct             if_instr[31:26] / if_instr[5:0] to control_unit
module instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              if_valid,
  output logic [5:0]        opcode,
  output logic [5:0]        funct
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;

  logic              skid_load, skid_unload, skid_flush;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc_plus4;

  logic              slot_free;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [1:0]        unused_redirect_lsb;

  assign slot_free           = !valid_q || !stall;
  assign pc_next             = pc_q + ADDR_W'(4);
  assign redirect_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    // A consumed instruction leaves the register empty unless refilled below.
    valid_d      = valid_q && stall;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;

    if (redirect_en) begin
      pc_d       = redirect_tgt;
      valid_d    = 1'b0;
      skid_flush = 1'b1;
      case (state_q)
        REQ: begin
          if (!imem_ack) begin
            // Old address must stay on the bus until its ack arrives.
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end
        // An ack here retires the wrong-path request, so nothing is left to drain.
        DRAIN:   state_d = imem_ack ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (slot_free) state_d = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            pc_d = pc_next;
            if (slot_free) begin
              instr_d    = imem_rdata;
              pc_plus4_d = pc_next;
              valid_d    = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = SKID;
            end
          end
        end
        SKID: begin
          if (!stall) begin
            instr_d     = skid_instr;
            pc_plus4_d  = skid_pc_plus4;
            valid_d     = 1'b1;
            skid_unload = 1'b1;
            state_d     = REQ;
          end
        end
        DRAIN: begin
          if (imem_ack) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      drain_addr_q <= PC_RESET;
      instr_q      <= NOP;
      pc_plus4_q   <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .unload       (skid_unload),
    .flush        (skid_flush),
    .in_instr     (imem_rdata),
    .in_pc_plus4  (pc_next),
    .out_instr    (skid_instr),
    .out_pc_plus4 (skid_pc_plus4)
  );

  assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign if_instr    = instr_q;
  assign if_pc_plus4 = pc_plus4_q;
  assign if_valid    = valid_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  // Memory model: ack once the request has been up for 'lat' earlier cycles.
  int unsigned lat;
  int unsigned cnt;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W   (32),
    .PC_RESET (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_instr    (if_instr),
    .if_pc_plus4 (if_pc_plus4),
    .if_valid    (if_valid),
    .opcode      (opcode),
    .funct       (funct)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {OP_SW, a[27:2]};
  endfunction

  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = instr_at(imem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_path(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.instr = instr_at(start + 32'(4 * i));
      e.pc4   = start + 32'(4 * i + 4);
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every consumed instruction must be the next one in program order.
  always @(negedge clk) begin
    if (!rst && if_valid && !stall) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL consume_unexpected: got=%h exp=none", if_instr);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("consume_instr", if_instr, e.instr);
        chk("consume_pc4", if_pc_plus4, e.pc4);
        n_pop++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    lat         = 0;
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc4", if_pc_plus4, 32'h0);

    // Reset release, zero-latency memory.
    push_path(32'h0, 16);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    step(1);
    chk("c2_valid", {31'b0, if_valid}, 32'd1);
    chk("c2_instr", if_instr, 32'h2008_0005);
    chk("c2_opcode", {26'b0, opcode}, {26'b0, OP_ADDI});
    chk("c2_funct", {26'b0, funct}, 32'd5);
    chk("c2_pc4", if_pc_plus4, 32'h4);
    chk("c2_addr", imem_addr, 32'h4);

    // Stall for 3 cycles while addr 8 is acked: parked in skid.
    step(1);
    stall = 1'b1;
    step(1);
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_instr", if_instr, instr_at(32'h4));
    step(2);
    chk("stall_req2", {31'b0, imem_req}, 32'd0);
    chk("stall_valid", {31'b0, if_valid}, 32'd1);
    stall = 1'b0;
    step(1);
    chk("unskid_instr", if_instr, instr_at(32'h8));
    chk("unskid_req", {31'b0, imem_req}, 32'd1);
    chk("unskid_addr", imem_addr, 32'hC);

    // Redirect during REQ with 2-cycle memory: old address drains.
    step(2);
    lat         = 2;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0043;
    step(1);
    redirect_en = 1'b0;
    exp_q.delete();
    push_path(32'h40, 8);
    chk("drain_valid", {31'b0, if_valid}, 32'd0);
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h14);
    step(1);
    chk("drain_hold", imem_addr, 32'h14);
    step(1);
    chk("drain_done_addr", imem_addr, 32'h40);
    chk("drain_discard", {31'b0, if_valid}, 32'd0);
    step(3);
    chk("tgt_instr", if_instr, instr_at(32'h40));
    chk("tgt_pc4", if_pc_plus4, 32'h44);
    lat = 0;

    // Redirect coinciding with ack and stall on a full output register.
    step(1);
    stall       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0100;
    step(1);
    redirect_en = 1'b0;
    exp_q.delete();
    push_path(32'h100, 8);
    chk("rd_ack_valid", {31'b0, if_valid}, 32'd0);
    chk("rd_ack_req", {31'b0, imem_req}, 32'd1);
    chk("rd_ack_addr", imem_addr, 32'h100);
    step(1);
    chk("rd_ack_instr", if_instr, instr_at(32'h100));
    chk("rd_ack_pc4", if_pc_plus4, 32'h104);
    step(1);
    chk("rd_skid_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    step(1);
    chk("rd_skid_instr", if_instr, instr_at(32'h104));
    chk("rd_skid_addr", imem_addr, 32'h108);

    // PC wrap at the top of the address space.
    step(2);
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_en = 1'b0;
    exp_q.delete();
    push_path(32'hFFFF_FFFC, 8);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_instr", if_instr, instr_at(32'hFFFF_FFFC));
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);

    // Reset in the middle of DRAIN.
    step(2);
    lat         = 3;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0200;
    step(1);
    redirect_en = 1'b0;
    exp_q.delete();
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    chk("pre_rst_valid", {31'b0, if_valid}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    lat   = 0;
    n_pop = 0;
    push_path(32'h0, 8);
    step(1);
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    for (int i = 0; i < 50 && n_pop < 8; i++) step(1);
    chk("post_rst_count", 32'(n_pop), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
